// File: rtl/core_general.sv
// core_general: shared RV32 core widths, decoded-op bundle layout and load/store funct3 codes
package core_general;
    localparam int XLEN         = 32;
    localparam int AWIDTH       = 14;
    localparam int OPLEN        = 9;
    localparam int FUNCT3_BIT_M = 2;
    localparam int FUNCT3_BIT_L = 0;
    localparam int DATA_MEM_WE  = 3;
    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;
    typedef struct packed {
        logic [OPLEN-1:0] decoded_op;
        logic             jump_state;
        logic [4:0]       rdsel;
        logic [XLEN-1:0]  next_pc;
        logic [XLEN-1:0]  alu_out;
        logic [XLEN-1:0]  rs2data;
    } em_regs_t;
    function automatic logic [2:0] funct3_of(input logic [OPLEN-1:0] op);
        return op[FUNCT3_BIT_M:FUNCT3_BIT_L];
    endfunction
endpackage

// File: rtl/memory_access_load_extend.sv
// memory_access_load_extend: picks the low byte/half/word of load data and sign- or zero-extends it
module memory_access_load_extend
    import core_general::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] ext_o
);
    // Lane selection always uses the low bits; unknown funct3 codes pass the word through
    always_comb begin
        ext_o = (funct3_i == FUNCT3_B)  ? {{(XLEN-8){data_i[7]}}, data_i[7:0]} :
                (funct3_i == FUNCT3_H)  ? {{(XLEN-16){data_i[15]}}, data_i[15:0]} :
                (funct3_i == FUNCT3_W)  ? data_i :
                (funct3_i == FUNCT3_BU) ? {{(XLEN-8){1'b0}}, data_i[7:0]} :
                (funct3_i == FUNCT3_HU) ? {{(XLEN-16){1'b0}}, data_i[15:0]} :
                data_i;
    end
endmodule

// File: rtl/memory_access.sv
// memory_access: MemoryAccess stage - latches Execute results, drives data memory, extends load data
module memory_access
    import core_general::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              phase_fetch,
    input  logic              phase_decode,
    input  logic              phase_execute,
    input  logic              phase_memoryaccess,
    input  logic              phase_writeback,
    input  logic [XLEN-1:0]   data_mem_out,
    input  logic [OPLEN-1:0]  decoded_op_em,
    input  logic              jump_state_em,
    input  logic [4:0]        rdsel_em,
    input  logic [XLEN-1:0]   next_pc_em,
    input  logic [XLEN-1:0]   alu_out_em,
    input  logic [XLEN-1:0]   rs2data_em,
    output logic [AWIDTH-1:0] data_mem_addr,
    output logic [XLEN-1:0]   data_mem_wdata,
    output logic [2:0]        data_mem_we,
    output logic [OPLEN-1:0]  decoded_op_mw,
    output logic              jump_state_mw,
    output logic [4:0]        rdsel_mw,
    output logic [XLEN-1:0]   next_pc_mw,
    output logic [XLEN-1:0]   alu_out_mw,
    output logic [XLEN-1:0]   mem_out_mw,
    output logic              stall_memoryaccess
);
    em_regs_t   pipe_q;
    em_regs_t   pipe_d;
    em_regs_t   pipe_em;
    logic [2:0] funct3_mw;
    logic       unused_phases;

    assign pipe_em = '{decoded_op: decoded_op_em, jump_state: jump_state_em, rdsel: rdsel_em,
                       next_pc: next_pc_em, alu_out: alu_out_em, rs2data: rs2data_em};

    // Capture Execute results at the closing edge of the execute phase, otherwise hold
    always_comb begin
        pipe_d = phase_execute ? pipe_em : pipe_q;
    end

    // Pipeline register; reset clears it immediately, independent of the clock
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) pipe_q <= '0;
        else       pipe_q <= pipe_d;
    end

    assign funct3_mw          = funct3_of(pipe_q.decoded_op);
    assign decoded_op_mw      = pipe_q.decoded_op;
    assign jump_state_mw      = pipe_q.jump_state;
    assign rdsel_mw           = pipe_q.rdsel;
    assign next_pc_mw         = pipe_q.next_pc;
    assign alu_out_mw         = pipe_q.alu_out;
    assign data_mem_addr      = pipe_q.alu_out[AWIDTH-1:0];
    assign data_mem_wdata     = pipe_q.rs2data;
    assign data_mem_we        = {pipe_q.decoded_op[DATA_MEM_WE] & phase_memoryaccess, funct3_mw[1:0]};
    assign stall_memoryaccess = 1'b0;
    assign unused_phases      = ^{phase_fetch, phase_decode, phase_writeback};

    memory_access_load_extend u_load_extend (
        .funct3_i (funct3_mw),
        .data_i   (data_mem_out),
        .ext_o    (mem_out_mw)
    );
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized + directed scoreboard bench for the MemoryAccess stage
module tb_memory_access;
    import core_general::*;

    logic clk = 0;
    logic rst_n = 1;
    logic phase_fetch = 0, phase_decode = 0, phase_execute = 0, phase_memoryaccess = 0, phase_writeback = 0;
    logic [31:0] data_mem_out = 0;
    logic [8:0]  decoded_op_em = 0;
    logic        jump_state_em = 0;
    logic [4:0]  rdsel_em = 0;
    logic [31:0] next_pc_em = 0, alu_out_em = 0, rs2data_em = 0;
    logic [13:0] data_mem_addr;
    logic [31:0] data_mem_wdata;
    logic [2:0]  data_mem_we;
    logic [8:0]  decoded_op_mw;
    logic        jump_state_mw;
    logic [4:0]  rdsel_mw;
    logic [31:0] next_pc_mw, alu_out_mw, mem_out_mw;
    logic        stall_memoryaccess;

    typedef struct {
        logic [8:0]  op;
        logic        js;
        logic [4:0]  rd;
        logic [31:0] pc, alu, rs2, d, out;
        logic [2:0]  we;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic        we;
        logic [31:0] d, out;
        logic [2:0]  xwe;
    } dir_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1;

    memory_access dut (
        .clk(clk), .rst_n(rst_n),
        .phase_fetch(phase_fetch), .phase_decode(phase_decode), .phase_execute(phase_execute),
        .phase_memoryaccess(phase_memoryaccess), .phase_writeback(phase_writeback),
        .data_mem_out(data_mem_out), .decoded_op_em(decoded_op_em), .jump_state_em(jump_state_em),
        .rdsel_em(rdsel_em), .next_pc_em(next_pc_em), .alu_out_em(alu_out_em), .rs2data_em(rs2data_em),
        .data_mem_addr(data_mem_addr), .data_mem_wdata(data_mem_wdata), .data_mem_we(data_mem_we),
        .decoded_op_mw(decoded_op_mw), .jump_state_mw(jump_state_mw), .rdsel_mw(rdsel_mw),
        .next_pc_mw(next_pc_mw), .alu_out_mw(alu_out_mw), .mem_out_mw(mem_out_mw),
        .stall_memoryaccess(stall_memoryaccess)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Load result from the ISA definition: take low byte/half as a number, extend by value range
    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] b, h;
        b = d % 256;
        h = d % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    task automatic scramble_em();
        decoded_op_em = 9'($urandom);
        jump_state_em = 1'($urandom);
        rdsel_em      = 5'($urandom);
        next_pc_em    = $urandom;
        alu_out_em    = $urandom;
        rs2data_em    = $urandom;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " we"}, 32'(data_mem_we), 0);
        chk({tag, " op"}, 32'(decoded_op_mw), 0);
        chk({tag, " js"}, 32'(jump_state_mw), 0);
        chk({tag, " rd"}, 32'(rdsel_mw), 0);
        chk({tag, " pc"}, next_pc_mw, 0);
        chk({tag, " alu"}, alu_out_mw, 0);
        chk({tag, " addr"}, 32'(data_mem_addr), 0);
        chk({tag, " wdata"}, data_mem_wdata, 0);
        chk({tag, " memout"}, mem_out_mw, ext_model(3'd0, data_mem_out));
    endtask

    task automatic tx(input logic [2:0] f3, input logic we, input logic [31:0] d,
                      input bit have_exp, input logic [31:0] xo, input logic [2:0] xw, input bit mid_rst);
        exp_t e;
        @(posedge clk); #1;
        scramble_em();
        decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L] = f3;
        decoded_op_em[DATA_MEM_WE] = we;
        if ($urandom_range(0, 3) == 0) begin
            next_pc_em = $urandom_range(0, 32'hFFFF);
            alu_out_em = $urandom_range(0, 32'hFFFF);
        end
        phase_execute = 1;
        e.op = decoded_op_em; e.js = jump_state_em; e.rd = rdsel_em;
        e.pc = next_pc_em; e.alu = alu_out_em; e.rs2 = rs2data_em; e.d = d;
        e.we  = have_exp ? xw : {we, f3[1:0]};
        e.out = have_exp ? xo : ext_model(f3, d);
        q.push_back(e);
        @(posedge clk); #1;
        phase_execute = 0;
        phase_memoryaccess = 1;
        scramble_em();
        data_mem_out = $urandom;
        if (mid_rst) begin
            #6;
            data_mem_out = 32'h0000_0080;
            rst_n = 1;
            #1;
            check_zero("midrst");
            e = q.pop_front();
            phase_memoryaccess = 0;
            @(posedge clk); #1;
            rst_n = 0;
        end else begin
            @(posedge clk); #1;
            phase_memoryaccess = 0;
            phase_writeback = 1;
            data_mem_out = d;
            scramble_em();
            @(posedge clk); #1;
            phase_writeback = 0;
        end
    endtask

    // Monitor: the memoryaccess phase presents the memory request, writeback presents load data
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst_n && (phase_memoryaccess || phase_writeback)) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard: got output with queue size 0 expected an entry");
                end else begin
                    chk("stall", 32'(stall_memoryaccess), 0);
                    chk("op_mw", 32'(decoded_op_mw), 32'(q[0].op));
                    chk("js_mw", 32'(jump_state_mw), 32'(q[0].js));
                    chk("rd_mw", 32'(rdsel_mw), 32'(q[0].rd));
                    chk("pc_mw", next_pc_mw, q[0].pc);
                    chk("alu_mw", alu_out_mw, q[0].alu);
                    if (phase_memoryaccess) begin
                        chk("we_mem", 32'(data_mem_we), 32'(q[0].we));
                        chk("addr", 32'(data_mem_addr), q[0].alu % 16384);
                        chk("wdata", data_mem_wdata, q[0].rs2);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("we_wb", 32'(data_mem_we), 32'(e.we[1:0]));
                        chk("mem_out", mem_out_mw, e.out);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        dir_t dir[$];
        dir.push_back('{3'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100});
        dir.push_back('{3'd0, 1'b0, 32'h0000_00FF, 32'hFFFF_FFFF, 3'b000});
        dir.push_back('{3'd0, 1'b1, 32'h0000_0001, 32'h0000_0001, 3'b100});
        dir.push_back('{3'd0, 1'b0, 32'h5555_5555, 32'h0000_0055, 3'b000});
        dir.push_back('{3'd4, 1'b0, 32'hFFFF_FFFF, 32'h0000_00FF, 3'b000});
        dir.push_back('{3'd4, 1'b1, 32'h0000_AAAA, 32'h0000_00AA, 3'b100});
        dir.push_back('{3'd5, 1'b0, 32'hAAAA_AAAA, 32'h0000_AAAA, 3'b001});
        dir.push_back('{3'd1, 1'b1, 32'hAAAA_AAAA, 32'hFFFF_AAAA, 3'b101});
        dir.push_back('{3'd1, 1'b0, 32'hFFFF_0000, 32'h0000_0000, 3'b001});
        dir.push_back('{3'd1, 1'b0, 32'h0000_8000, 32'hFFFF_8000, 3'b001});
        dir.push_back('{3'd2, 1'b1, 32'hFFFF_0000, 32'hFFFF_0000, 3'b110});
        dir.push_back('{3'd2, 1'b0, 32'h1234_5678, 32'h1234_5678, 3'b010});
        dir.push_back('{3'd3, 1'b1, 32'h8765_4321, 32'h8765_4321, 3'b111});
        dir.push_back('{3'd6, 1'b0, 32'h8000_8080, 32'h8000_8080, 3'b010});
        dir.push_back('{3'd7, 1'b1, 32'h0000_8080, 32'h0000_8080, 3'b111});
        scramble_em();
        phase_execute = 1;
        repeat (2) @(posedge clk);
        #3;
        check_zero("reset");
        phase_execute = 0;
        @(posedge clk); #1;
        rst_n = 0;
        foreach (dir[i]) tx(dir[i].f3, dir[i].we, dir[i].d, 1, dir[i].out, dir[i].xwe, 0);
        for (int i = 0; i < 150; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (i % 5 == 0) d = d & 32'h0000_FFFF;
            tx(3'($urandom), 1'($urandom), d, 0, 0, 0, 0);
        end
        tx(3'd2, 1'b1, 32'hCAFE_F00D, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) tx(3'($urandom), 1'($urandom), $urandom, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
